// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset level, NOP encoding, FSM states.
// The HOLD state only exists when FETCH_SKID_EN is defined.
package inst_fetch_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] NopInst     = 32'h0000_0000;
    localparam logic [31:0] PcStep      = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01
`ifdef FETCH_SKID_EN
        ,HOLD = 2'b10
`endif
    } fetch_state_e;

    function automatic logic [InstAddrBus-1:0] wordAlign(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_skid.sv
// One-entry skid buffer holding an instruction fetched while decode was stalled.
// Only instantiated when FETCH_SKID_EN is defined.
module fetch_skid_buf
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   drain_i,
    input  logic                   clear_i,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic [InstBus-1:0]     inst_i,
    output logic                   valid_o,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    logic                   valid_q;
    logic [InstAddrBus-1:0] pc_q;
    logic [InstBus-1:0]     inst_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= 1'b0;
            pc_q    <= ZeroWord;
            inst_q  <= NopInst;
        end else if (clear_i || drain_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word reads to imem and presents pc/instruction to decode.
// Define FETCH_SKID_EN to keep fetching through a stall with a one-entry skid buffer.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] new_pc_i,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [InstBus-1:0]     imem_data_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    localparam logic [InstAddrBus-1:0] ResetPcAligned = {RESET_PC[InstAddrBus-1:2], 2'b00};

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] fetchPc_q, fetchPc_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic                   imemReq;

`ifdef FETCH_SKID_EN
    logic                   skidLoad, skidDrain, skidClear, skidValid;
    logic [InstAddrBus-1:0] skidPc;
    logic [InstBus-1:0]     skidInst;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skidLoad),
        .drain_i (skidDrain),
        .clear_i (skidClear),
        .pc_i    (fetchPc_q),
        .inst_i  (imem_data_i),
        .valid_o (skidValid),
        .pc_o    (skidPc),
        .inst_o  (skidInst)
    );
`endif

    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        imemReq   = 1'b0;
`ifdef FETCH_SKID_EN
        skidLoad  = 1'b0;
        skidDrain = 1'b0;
        skidClear = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (!stall_i) inst_d = NopInst;
            end
            REQ: begin
`ifdef FETCH_SKID_EN
                imemReq = 1'b1;
`else
                imemReq = !stall_i;
`endif
                if (!stall_i) begin
                    if (imem_ack_i) begin
                        pc_d      = fetchPc_q;
                        inst_d    = imem_data_i;
                        fetchPc_d = fetchPc_q + PcStep;
                    end else begin
                        inst_d = NopInst;
                    end
                end
`ifdef FETCH_SKID_EN
                else if (imem_ack_i) begin
                    skidLoad  = 1'b1;
                    fetchPc_d = fetchPc_q + PcStep;
                    state_d   = HOLD;
                end
`endif
            end
`ifdef FETCH_SKID_EN
            HOLD: begin
                if (!stall_i) begin
                    state_d = REQ;
                    if (skidValid) begin
                        pc_d      = skidPc;
                        inst_d    = skidInst;
                        skidDrain = 1'b1;
                    end else begin
                        inst_d = NopInst;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A redirect overrides any same-cycle ack, stall or skid activity.
        if (flush_i) begin
            fetchPc_d = wordAlign(new_pc_i);
            pc_d      = pc_q;
            inst_d    = NopInst;
            state_d   = REQ;
`ifdef FETCH_SKID_EN
            skidLoad  = 1'b0;
            skidDrain = 1'b0;
            skidClear = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= IDLE;
            fetchPc_q <= ResetPcAligned;
            pc_q      <= ZeroWord;
            inst_q    <= NopInst;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
        end
    end

    assign imem_req_o  = imemReq;
    assign imem_addr_o = fetchPc_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then randomized traffic against a cycle-level reference model.
// Works with or without FETCH_SKID_EN.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   localparam int PH_IDLE = 0;
   localparam int PH_REQ  = 1;
   localparam int PH_HOLD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] new_pc_i = 32'h0;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_data_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;

   int checks = 0;
   int errors = 0;

   // Reference model: what decode should see, where fetch is, and what the skid holds.
   int          phase = PH_IDLE;
   bit          known = 1'b0;
   logic [31:0] mPc, mInst, mFetch, sPc, sInst;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .new_pc_i    (new_pc_i),
      .imem_req_o  (imem_req_o),
      .imem_addr_o (imem_addr_o),
      .imem_ack_i  (imem_ack_i),
      .imem_data_i (imem_data_i),
      .pc_o        (pc_o),
      .inst_o      (inst_o)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0) return 32'h3401_1100;
      if (a == 32'h4) return 32'h3402_0020;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit expReq(input bit s);
      if (phase != PH_REQ) return 1'b0;
      return SKID ? 1'b1 : !s;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the rules for reset, redirect, stall and ack.
   task automatic stepModel(input bit r, input bit s, input bit f, input logic [31:0] np, input bit a);
      if (r) begin
         mPc = 32'h0; mInst = 32'h0; mFetch = RESET_PC; phase = PH_IDLE;
      end else if (f) begin
         mFetch = {np[31:2], 2'b00}; mInst = 32'h0; phase = PH_REQ;
      end else if (phase == PH_IDLE) begin
         phase = PH_REQ;
         if (!s) mInst = 32'h0;
      end else if (phase == PH_REQ) begin
         if (!s) begin
            if (a) begin
               mPc = mFetch; mInst = memWord(mFetch); mFetch = mFetch + 32'd4;
            end else begin
               mInst = 32'h0;
            end
         end else if (SKID && a) begin
            sPc = mFetch; sInst = memWord(mFetch); mFetch = mFetch + 32'd4; phase = PH_HOLD;
         end
      end else if (!s) begin
         mPc = sPc; mInst = sInst; phase = PH_REQ;
      end
   endtask

   task automatic applyStimulus(input bit r, input bit s, input bit f, input logic [31:0] np, input bit a);
      bit er;
      @(negedge clk);
      rst = r; stall_i = s; flush_i = f; new_pc_i = np; imem_ack_i = 1'b0;
      #1;
      er = expReq(s);
      if (known) begin
         checkOutput("imem_req", {31'b0, imem_req_o}, {31'b0, er});
         if (er) checkOutput("imem_addr", imem_addr_o, mFetch);
      end
      imem_ack_i  = a;
      imem_data_i = memWord(imem_addr_o);
      @(posedge clk);
      stepModel(r, s, f, np, a);
      known = 1'b1;
      #1;
      checkOutput("pc_o", pc_o, mPc);
      checkOutput("inst_o", inst_o, mInst);
   endtask

   initial begin
      $display("[TB] start, skid=%0d", SKID);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("reset_pc", pc_o, 32'h0);
      checkOutput("reset_inst", inst_o, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("first_pc", pc_o, 32'h0);
      checkOutput("first_inst", inst_o, 32'h3401_1100);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("second_pc", pc_o, 32'h4);
      checkOutput("second_inst", inst_o, 32'h3402_0020);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wait_addr", imem_addr_o, 32'h8);
      checkOutput("wait_inst", inst_o, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("late_pc", pc_o, 32'h8);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1);
      checkOutput("stall_pc", pc_o, 32'h8);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("unstall_pc", pc_o, 32'hC);
      checkOutput("unstall_inst", inst_o, memWord(32'hC));
      applyStimulus(0, 0, 1, 32'h0000_0103, 1);
      checkOutput("flush_inst", inst_o, 32'h0);
      checkOutput("flush_addr", imem_addr_o, 32'h100);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("redirect_pc", pc_o, 32'h100);
      applyStimulus(0, 1, 1, 32'hFFFF_FFFC, 1);
      checkOutput("flush_stall_inst", inst_o, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wrap_pc", pc_o, 32'hFFFF_FFFC);
      checkOutput("wrap_addr", imem_addr_o, 32'h0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("rst_mid_pc", pc_o, 32'h0);
      checkOutput("rst_mid_inst", inst_o, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("restart_inst", inst_o, 32'h3401_1100);
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(39) == 0), ($urandom_range(3) == 0),
                       ($urandom_range(9) == 0), $urandom, ($urandom_range(1) == 1));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
